// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: holds a one-hot grant for a whole burst (until last
// is accepted or the requester drops out) and drives the AND-OR mux it selects.

module rr_burst_arbiter_lane #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic              req,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  output logic              sel_req,
  output logic              sel_last,
  output logic [DATA_W-1:0] sel_data
);
  assign sel_req  = sel & req;
  assign sel_last = sel & last;
  assign sel_data = data & {DATA_W{sel}};
endmodule

module rr_burst_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  input  logic [N_REQ-1:0]        last_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic                    valid_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    last_o,
  input  logic                    ready_i,
  output logic                    busy_o
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                         state_q, state_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic [N_REQ-1:0]               gnt_q, gnt_d;
  logic [PTR_W-1:0]               win_idx, scan_idx, gnt_idx;
  logic                           release_grant;
  logic [N_REQ-1:0]               lane_req, lane_last;
  logic [N_REQ-1:0][DATA_W-1:0]   lane_data;

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    rr_burst_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .sel      (gnt_q[k]),
      .req      (req_i[k]),
      .last     (last_i[k]),
      .data     (data_i[k*DATA_W +: DATA_W]),
      .sel_req  (lane_req[k]),
      .sel_last (lane_last[k]),
      .sel_data (lane_data[k])
    );
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q == GRANT);
  assign valid_o = |lane_req;
  assign last_o  = |lane_last;

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N_REQ; k++) data_o = data_o | lane_data[k];
  end

  // Scan from the furthest offset down so the requester closest to ptr wins.
  always_comb begin
    win_idx  = '0;
    scan_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (req_i[scan_idx]) win_idx = scan_idx;
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) if (gnt_q[k]) gnt_idx = PTR_W'(k);
  end

  // Dropping the request while granted counts as an abandon and frees the channel.
  assign release_grant = (state_q == GRANT) && (!valid_o || (ready_i && last_o));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(1) << win_idx;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed scenarios plus random traffic checked
// against an index-based reference model of the arbitration rules.

module tb_rr_burst_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   last_i;
  logic [N-1:0]   gnt_o;
  logic           valid_o;
  logic [W-1:0]   data_o;
  logic           last_o;
  logic           ready_i;
  logic           busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int m_g   = -1;   // granted requester, -1 when idle
  int m_ptr = 0;

  rr_burst_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i), .last_i(last_i),
    .gnt_o(gnt_o), .valid_o(valid_o), .data_o(data_o), .last_o(last_o),
    .ready_i(ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

  function automatic logic [14:0] exp_vec();
    if (m_g < 0) return '0;
    return {4'(1 << m_g), req_i[m_g], data_i[m_g*W +: W], last_i[m_g], 1'b1};
  endfunction

  task automatic set_in(input bit r, input logic [3:0] rq, input logic [31:0] d,
                        input logic [3:0] l, input bit rdy);
    @(negedge clk_i);
    rst_ni = r; req_i = rq; data_i = d; last_i = l; ready_i = rdy;
    #1;
  endtask

  // Advance the reference model across one rising edge.
  task automatic tick();
    @(posedge clk_i);
    if (!rst_ni) begin
      m_g = -1; m_ptr = 0;
    end else if (m_g < 0) begin
      for (int i = 0; i < N; i++)
        if (m_g < 0 && req_i[(m_ptr + i) % N]) m_g = (m_ptr + i) % N;
    end else if (!req_i[m_g] || (ready_i && last_i[m_g])) begin
      m_ptr = (m_g + 1) % N;
      m_g   = -1;
    end
  endtask

  task automatic do_reset();
    set_in(0, 4'b0000, '0, 4'b0000, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    set_in(0, 4'b1111, $urandom, 4'b1111, 1'b1); tick();
    set_in(0, 4'b1111, $urandom, 4'b1111, 1'b1); tick();
    set_in(0, 4'b1111, $urandom, 4'b1111, 1'b1);
    n_cmp++;
    if ({gnt_o, valid_o, data_o, last_o, busy_o} !== 15'd0) begin
      n_err++; $display("FAIL reset_hold: got %h want 0", {gnt_o, valid_o, data_o, last_o, busy_o});
    end
    tick();
    set_in(1, 4'b1111, 32'h44332211, 4'b0000, 1'b0);
    n_cmp++;
    if ({gnt_o, busy_o, valid_o} !== 6'd0) begin
      n_err++; $display("FAIL reset_idle: got %b want 0", {gnt_o, busy_o, valid_o});
    end
    tick();
    set_in(1, 4'b1111, 32'h44332211, 4'b0000, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0001 || data_o !== 8'h11) begin
      n_err++; $display("FAIL reset_first_gnt: got gnt %b data %h want 0001 11", gnt_o, data_o);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      set_in(1, 4'b1111, $urandom, 4'b1111, 1'b1);
      want = (c % 2 == 0) ? 4'b0000 : 4'(1 << ((c / 2) % 4));
      n_cmp++;
      if (gnt_o !== want || {gnt_o, valid_o, data_o, last_o, busy_o} !== exp_vec()) begin
        n_err++; $display("FAIL rotation c=%0d: got gnt %b vec %h want gnt %b vec %h",
                          c, gnt_o, {gnt_o, valid_o, data_o, last_o, busy_o}, want, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit rdy_seq [5] = '{1, 0, 1, 0, 1};
    int b = 0;
    do_reset();
    set_in(1, 4'b0100, {8'h00, 8'hA0, 8'h00, 8'h55}, 4'b0000, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 4'b0101, {8'h00, 8'(8'hA0 + b), 8'h00, 8'h55}, {1'b0, b == 2, 2'b00}, rdy_seq[i]);
      n_cmp++;
      if (gnt_o !== 4'b0100 || data_o !== 8'(8'hA0 + b) || valid_o !== 1'b1 ||
          last_o !== (b == 2) || {gnt_o, valid_o, data_o, last_o, busy_o} !== exp_vec()) begin
        n_err++; $display("FAIL burst_hold i=%0d: got gnt %b data %h last %b want 0100 %h %b",
                          i, gnt_o, data_o, last_o, 8'(8'hA0 + b), b == 2);
      end
      tick();
      if (rdy_seq[i]) b++;
    end
    set_in(1, 4'b0101, {8'h00, 8'h00, 8'h00, 8'h55}, 4'b0000, 1'b1);
    n_cmp++;
    if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL burst_bubble: got gnt %b busy %b want 0000 0", gnt_o, busy_o);
    end
    tick();
    set_in(1, 4'b0101, {8'h00, 8'h00, 8'h00, 8'h55}, 4'b0000, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0001 || data_o !== 8'h55) begin
      n_err++; $display("FAIL burst_next: got gnt %b data %h want 0001 55", gnt_o, data_o);
    end
  endtask

  task automatic test_skip_ahead();
    do_reset();
    set_in(1, 4'b0001, '0, 4'b0001, 1'b1); tick();
    set_in(1, 4'b0001, '0, 4'b0001, 1'b1); tick();
    set_in(1, 4'b1001, '0, 4'b0000, 1'b0); tick();
    set_in(1, 4'b1001, 32'hC3000000, 4'b1000, 1'b1);
    n_cmp++;
    if (gnt_o !== 4'b1000 || data_o !== 8'hC3 || last_o !== 1'b1) begin
      n_err++; $display("FAIL skip_winner: got gnt %b data %h last %b want 1000 c3 1", gnt_o, data_o, last_o);
    end
    tick();
    set_in(1, 4'b1111, '0, 4'b0000, 1'b0); tick();
    set_in(1, 4'b1111, '0, 4'b0000, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0001) begin
      n_err++; $display("FAIL skip_wrap: got gnt %b want 0001", gnt_o);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    set_in(1, 4'b0010, '0, 4'b0000, 1'b1); tick();
    set_in(1, 4'b0010, 32'h00007700, 4'b0000, 1'b1);
    n_cmp++;
    if (gnt_o !== 4'b0010 || valid_o !== 1'b1 || data_o !== 8'h77) begin
      n_err++; $display("FAIL abandon_beat: got gnt %b valid %b data %h want 0010 1 77", gnt_o, valid_o, data_o);
    end
    tick();
    set_in(1, 4'b0000, 32'h00007800, 4'b0000, 1'b1);
    n_cmp++;
    if (valid_o !== 1'b0 || gnt_o !== 4'b0010 || busy_o !== 1'b1) begin
      n_err++; $display("FAIL abandon_drop: got valid %b gnt %b busy %b want 0 0010 1", valid_o, gnt_o, busy_o);
    end
    tick();
    set_in(1, 4'b0101, '0, 4'b0000, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0000) begin
      n_err++; $display("FAIL abandon_release: got gnt %b want 0000", gnt_o);
    end
    tick();
    set_in(1, 4'b0101, '0, 4'b0000, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0100) begin
      n_err++; $display("FAIL abandon_ptr: got gnt %b want 0100", gnt_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_in(1, 4'b1000, 32'h01000000, 4'b0000, 1'b1); tick();
    set_in(1, 4'b1000, 32'h01000000, 4'b0000, 1'b1); tick();
    set_in(0, 4'b1000, 32'h02000000, 4'b0000, 1'b1);
    n_cmp++;
    if (gnt_o !== 4'b1000 || data_o !== 8'h02) begin
      n_err++; $display("FAIL midrst_beat2: got gnt %b data %h want 1000 02", gnt_o, data_o);
    end
    tick();
    set_in(1, 4'b1010, 32'h02000000, 4'b1000, 1'b1);
    n_cmp++;
    if ({gnt_o, valid_o, data_o, last_o, busy_o} !== 15'd0) begin
      n_err++; $display("FAIL midrst_clear: got %h want 0", {gnt_o, valid_o, data_o, last_o, busy_o});
    end
    tick();
    set_in(1, 4'b1010, '0, 4'b0000, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0010) begin
      n_err++; $display("FAIL midrst_next: got gnt %b want 0010", gnt_o);
    end
  endtask

  task automatic test_random();
    logic [3:0] rq = 4'b0000;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(3) == 0) rq[k] = ~rq[k];
      set_in($urandom_range(49) != 0, rq, $urandom, 4'($urandom), 1'($urandom));
      n_cmp++;
      if ({gnt_o, valid_o, data_o, last_o, busy_o} !== exp_vec() || $countones(gnt_o) > 1) begin
        n_err++; $display("FAIL random c=%0d: got %h want %h", c,
                          {gnt_o, valid_o, data_o, last_o, busy_o}, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = '0; data_i = '0; last_i = '0; ready_i = 1'b0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_skip_ahead();
    test_abandon();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
